// File: rtl/load_buffer_unit.sv
// In-order load buffer: queues calculated loads, issues one word read at a time,
// extends the returned data and writes it back on the CDB. Optional LB_EARLY_WB_EN
// drives the CDB straight from the memory response.
module load_buffer_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             lb_valid,
    input  logic [XLEN-1:0]  lb_address,
    input  logic [TAG_W-1:0] lb_rd_tag,
    input  logic [2:0]       lb_mem_size,
    input  logic [XLEN-1:0]  lb_NPC,
    input  logic [31:0]      lb_inst,
    output logic             lb_ready,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             cdb_valid,
    output logic [XLEN-1:0]  cdb_value,
    output logic [TAG_W-1:0] cdb_rob_tag,
    output logic [XLEN-1:0]  cdb_NPC,
    output logic [31:0]      cdb_inst,
    input  logic             cdb_grant
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]  address;
        logic [TAG_W-1:0] tag;
        logic [2:0]       size;
        logic [XLEN-1:0]  npc;
        logic [31:0]      inst;
    } lb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WB    = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e           state_q, state_d;
    lb_entry_t        fifo_q [DEPTH];
    lb_entry_t        fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  wb_value_q, wb_value_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [XLEN-1:0]  wb_npc_q, wb_npc_d;
    logic [31:0]      wb_inst_q, wb_inst_d;

    lb_entry_t        head_c;
    logic             push_c;
    logic             pop_c;
    logic             early_c;
    logic [XLEN-1:0]  ext_value_c;

    // Sign/zero extension of the selected byte/halfword of an aligned word.
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extend = {{(XLEN-8){b[7]}}, b};
            3'b100:  extend = {{(XLEN-8){1'b0}}, b};
            3'b001:  extend = {{(XLEN-16){h[15]}}, h};
            3'b101:  extend = {{(XLEN-16){1'b0}}, h};
            3'b010:  extend = w;
            default: extend = XLEN'(32'hdeadbeef);
        endcase
    endfunction

    assign head_c      = fifo_q[rd_ptr_q];
    assign lb_ready    = (count_q != CNT_W'(DEPTH));
    assign push_c      = lb_valid & lb_ready & ~squash;
    assign pop_c       = (state_q == REQ) & mem_ack & ~squash;
    assign ext_value_c = extend(head_c.size, head_c.address[1:0], mem_rdata);

`ifdef LB_EARLY_WB_EN
    assign early_c = pop_c;
`else
    assign early_c = 1'b0;
`endif

    // State register and FIFO/writeback storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_value_q <= '0;
            wb_tag_q   <= '0;
            wb_npc_q   <= '0;
            wb_inst_q  <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_value_q <= wb_value_d;
            wb_tag_q   <= wb_tag_d;
            wb_npc_q   <= wb_npc_d;
            wb_inst_q  <= wb_inst_d;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
        end
    end

    // FIFO pointers, occupancy and writeback latch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) fifo_d[i] = fifo_q[i];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wb_value_d = wb_value_q;
        wb_tag_d   = wb_tag_q;
        wb_npc_d   = wb_npc_q;
        wb_inst_d  = wb_inst_q;
        if (push_c) begin
            fifo_d[wr_ptr_q] = '{address: lb_address, tag: lb_rd_tag, size: lb_mem_size,
                                 npc: lb_NPC, inst: lb_inst};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            wb_value_d = ext_value_c;
            wb_tag_d   = head_c.tag;
            wb_npc_d   = head_c.npc;
            wb_inst_d  = head_c.inst;
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        if (squash) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (count_q != '0) state_d = REQ;
            REQ: begin
                if (mem_ack) begin
                    if (early_c && cdb_grant) state_d = (count_q > CNT_W'(1)) ? REQ : IDLE;
                    else                      state_d = WB;
                end
            end
            WB:    if (cdb_grant) state_d = (count_q != '0) ? REQ : IDLE;
            DRAIN: if (mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // In DRAIN a squash changes nothing: the aborted ack must still be absorbed.
        if (squash && state_q != DRAIN) begin
            state_d = (state_q == REQ && !mem_ack) ? DRAIN : IDLE;
        end
    end

    // Output logic.
    always_comb begin
        mem_req     = 1'b0;
        mem_addr    = '0;
        cdb_valid   = 1'b0;
        cdb_value   = '0;
        cdb_rob_tag = '0;
        cdb_NPC     = '0;
        cdb_inst    = '0;
        if (state_q == REQ) begin
            mem_req  = 1'b1;
            mem_addr = {head_c.address[XLEN-1:2], 2'b00};
        end
        if (state_q == WB) begin
            cdb_valid   = 1'b1;
            cdb_value   = wb_value_q;
            cdb_rob_tag = wb_tag_q;
            cdb_NPC     = wb_npc_q;
            cdb_inst    = wb_inst_q;
        end
        if (early_c) begin
            cdb_valid   = 1'b1;
            cdb_value   = ext_value_c;
            cdb_rob_tag = head_c.tag;
            cdb_NPC     = head_c.npc;
            cdb_inst    = head_c.inst;
        end
    end

endmodule

// File: tb/tb_load_buffer_unit.sv
// Directed bench for load_buffer_unit: extension, FIFO order/backpressure,
// squash/drain, CDB hold and (with LB_EARLY_WB_EN) the early writeback path.
module tb_load_buffer_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned XLEN  = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             squash = 1'b0;
    logic             lb_valid = 1'b0;
    logic [XLEN-1:0]  lb_address = '0;
    logic [TAG_W-1:0] lb_rd_tag = '0;
    logic [2:0]       lb_mem_size = '0;
    logic [XLEN-1:0]  lb_NPC = '0;
    logic [31:0]      lb_inst = '0;
    logic             lb_ready;
    logic             mem_req;
    logic [XLEN-1:0]  mem_addr;
    logic             mem_ack = 1'b0;
    logic [XLEN-1:0]  mem_rdata = '0;
    logic             cdb_valid;
    logic [XLEN-1:0]  cdb_value;
    logic [TAG_W-1:0] cdb_rob_tag;
    logic [XLEN-1:0]  cdb_NPC;
    logic [31:0]      cdb_inst;
    logic             cdb_grant = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    load_buffer_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .lb_valid(lb_valid), .lb_address(lb_address), .lb_rd_tag(lb_rd_tag),
        .lb_mem_size(lb_mem_size), .lb_NPC(lb_NPC), .lb_inst(lb_inst),
        .lb_ready(lb_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_rob_tag(cdb_rob_tag),
        .cdb_NPC(cdb_NPC), .cdb_inst(cdb_inst), .cdb_grant(cdb_grant)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic set_load(input logic [31:0] addr, input int tag, input logic [2:0] f3);
        lb_valid    = 1'b1;
        lb_address  = addr;
        lb_rd_tag   = TAG_W'(tag);
        lb_mem_size = f3;
        lb_NPC      = addr + 32'h400;
        lb_inst     = 32'h0000_0003 | (addr << 12);
    endtask

    task automatic enq(input logic [31:0] addr, input int tag, input logic [2:0] f3);
        set_load(addr, tag, f3);
        @(negedge clock);
        lb_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("req_seen", 64'(mem_req), 64'd1);
    endtask

    task automatic do_load(input logic [31:0] addr, input int tag, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] expv);
        enq(addr, tag, f3);
        wait_req();
        check("mem_addr", 64'(mem_addr), 64'({addr[31:2], 2'b00}));
        mem_ack = 1'b1;
        mem_rdata = rdata;
        @(negedge clock);
        mem_ack = 1'b0;
        check("cdb_valid", 64'(cdb_valid), 64'd1);
        check("cdb_value", 64'(cdb_value), 64'(expv));
        check("cdb_tag", 64'(cdb_rob_tag), 64'(tag));
        check("cdb_npc", 64'(cdb_NPC), 64'(addr + 32'h400));
        cdb_grant = 1'b1;
        @(negedge clock);
        cdb_grant = 1'b0;
        check("cdb_drop", 64'(cdb_valid), 64'd0);
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_ready", 64'(lb_ready), 64'd1);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_cdb", 64'(cdb_valid), 64'd0);
        check("rst_val", 64'(cdb_value), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Extension cases
        do_load(32'h1002, 3, 3'b000, 32'h80FF_0000, 32'hFFFF_FFFF);
        do_load(32'h2002, 4, 3'b101, 32'h8001_1234, 32'h0000_8001);
        do_load(32'h2000, 5, 3'b001, 32'h8001_1234, 32'h0000_1234);
        do_load(32'h2000, 6, 3'b010, 32'h8001_1234, 32'h8001_1234);
        do_load(32'h3001, 7, 3'b100, 32'h0000_8000, 32'h0000_0080);
        do_load(32'h3003, 8, 3'b000, 32'h7F00_0000, 32'h0000_007F);
        do_load(32'h3000, 9, 3'b001, 32'h0000_F00F, 32'hFFFF_F00F);
        do_load(32'h3003, 10, 3'b010, 32'hCAFE_0001, 32'hCAFE_0001);
        do_load(32'h3000, 11, 3'b011, 32'h1111_1111, 32'hDEAD_BEEF);

        // Fill the FIFO with acks withheld; fifth load must be dropped
        for (int i = 1; i <= 4; i++) begin
            set_load(32'h100 + 32'(i * 4), i, 3'b010);
            @(negedge clock);
        end
        lb_valid = 1'b0;
        check("full_ready", 64'(lb_ready), 64'd0);
        set_load(32'h200, 5, 3'b010);
        @(negedge clock);
        lb_valid = 1'b0;
        check("full_ready2", 64'(lb_ready), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            wait_req();
            check("fill_addr", 64'(mem_addr), 64'(32'h100 + 32'(i * 4)));
            mem_ack = 1'b1;
            mem_rdata = 32'(i * 32'h11);
            @(negedge clock);
            mem_ack = 1'b0;
            check("fill_tag", 64'(cdb_rob_tag), 64'(i));
            check("fill_val", 64'(cdb_value), 64'(i * 32'h11));
            check("fill_ready", 64'(lb_ready), 64'd1);
            cdb_grant = 1'b1;
            @(negedge clock);
            cdb_grant = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            check("fill_noreq", 64'(mem_req), 64'd0);
            @(negedge clock);
        end

        // Squash in REQ with two queued loads, late ack drained
        set_load(32'h400, 12, 3'b010);
        @(negedge clock);
        set_load(32'h404, 13, 3'b010);
        @(negedge clock);
        lb_valid = 1'b0;
        wait_req();
        squash = 1'b1;
        @(negedge clock);
        squash = 1'b0;
        check("sq_ready", 64'(lb_ready), 64'd1);
        for (int k = 0; k < 2; k++) begin
            check("sq_noreq", 64'(mem_req), 64'd0);
            check("sq_nocdb", 64'(cdb_valid), 64'd0);
            @(negedge clock);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clock);
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("dr_nocdb", 64'(cdb_valid), 64'd0);
            check("dr_noreq", 64'(mem_req), 64'd0);
            @(negedge clock);
        end
        do_load(32'h500, 14, 3'b010, 32'hA5A5_0F0F, 32'hA5A5_0F0F);

        // Squash while in WB
        enq(32'h600, 15, 3'b010);
        wait_req();
        mem_ack = 1'b1;
        mem_rdata = 32'h55;
        @(negedge clock);
        mem_ack = 1'b0;
        check("wbsq_valid", 64'(cdb_valid), 64'd1);
        squash = 1'b1;
        @(negedge clock);
        squash = 1'b0;
        check("wbsq_drop", 64'(cdb_valid), 64'd0);
        check("wbsq_noreq", 64'(mem_req), 64'd0);

        // CDB held stable while grant is low; queued load waits
        enq(32'h700, 16, 3'b100);
        wait_req();
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_00F0;
        @(negedge clock);
        mem_ack = 1'b0;
        set_load(32'h704, 17, 3'b010);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 64'(cdb_valid), 64'd1);
            check("hold_val", 64'(cdb_value), 64'h0000_00F0);
            check("hold_tag", 64'(cdb_rob_tag), 64'd16);
            check("hold_noreq", 64'(mem_req), 64'd0);
            @(negedge clock);
            lb_valid = 1'b0;
        end
        cdb_grant = 1'b1;
        @(negedge clock);
        cdb_grant = 1'b0;
        check("hold_next_req", 64'(mem_req), 64'd1);
        check("hold_next_addr", 64'(mem_addr), 64'h704);
        mem_ack = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        @(negedge clock);
        mem_ack = 1'b0;
        check("hold2_tag", 64'(cdb_rob_tag), 64'd17);
        cdb_grant = 1'b1;
        @(negedge clock);
        cdb_grant = 1'b0;

        // Ack and grant in the same cycle
        set_load(32'h800, 18, 3'b010);
        @(negedge clock);
        set_load(32'h804, 19, 3'b010);
        @(negedge clock);
        lb_valid = 1'b0;
        wait_req();
        mem_ack = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        cdb_grant = 1'b1;
        #1;
`ifdef LB_EARLY_WB_EN
        check("early_valid", 64'(cdb_valid), 64'd1);
        check("early_val", 64'(cdb_value), 64'h1357_9BDF);
        check("early_tag", 64'(cdb_rob_tag), 64'd18);
        @(negedge clock);
        mem_ack = 1'b0;
        cdb_grant = 1'b0;
        check("early_next_req", 64'(mem_req), 64'd1);
        check("early_next_addr", 64'(mem_addr), 64'h804);
        check("early_nocdb", 64'(cdb_valid), 64'd0);
`else
        check("late_nocdb", 64'(cdb_valid), 64'd0);
        @(negedge clock);
        mem_ack = 1'b0;
        cdb_grant = 1'b0;
        check("late_valid", 64'(cdb_valid), 64'd1);
        check("late_val", 64'(cdb_value), 64'h1357_9BDF);
        check("late_noreq", 64'(mem_req), 64'd0);
        cdb_grant = 1'b1;
        @(negedge clock);
        cdb_grant = 1'b0;
        check("late_next_addr", 64'(mem_addr), 64'h804);
`endif
        wait_req();
        mem_ack = 1'b1;
        mem_rdata = 32'h2468_ACE0;
        @(negedge clock);
        mem_ack = 1'b0;
        check("ew2_tag", 64'(cdb_rob_tag), 64'd19);
        check("ew2_val", 64'(cdb_value), 64'h2468_ACE0);
        cdb_grant = 1'b1;
        @(negedge clock);
        cdb_grant = 1'b0;
        check("end_idle", 64'(mem_req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_buffer_unit.md
Name: load_buffer_unit

Overview:
- Consumer end of the load-address interface produced by the address-calculation unit.
- Accepts calculated load packets (address, ROB tag, size, PC info) into an in-order FIFO and issues one memory read at a time.
- Sign- or zero-extends the returned data per funct3 and broadcasts the result on the CDB as an execute/writeback packet under a grant handshake.
- Sits between the RS/address-calc stage and the CDB arbiter; flushed on branch misprediction.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- TAG_W, 5, ROB tag width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- squash  in  1  branch-misprediction flush
- lb_valid  in  1  load packet valid
- lb_address  in  XLEN  computed load address
- lb_rd_tag  in  TAG_W  destination ROB tag
- lb_mem_size  in  3  load funct3
- lb_NPC  in  XLEN  packet NPC
- lb_inst  in  32  instruction word
- lb_ready  out  1  FIFO not full (registered count)
- mem_req  out  1  read request
- mem_addr  out  XLEN  read address (word aligned: low 2 bits zero)
- mem_ack  in  1  response valid; mem_rdata valid this cycle
- mem_rdata  in  XLEN  aligned 32-bit word
- cdb_valid  out  1  writeback valid
- cdb_value  out  XLEN  extended load data
- cdb_rob_tag  out  TAG_W  tag
- cdb_NPC  out  XLEN  NPC
- cdb_inst  out  32  instruction
- cdb_grant  in  1  arbiter accepts cdb packet this cycle

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, FSM=IDLE, all outputs 0 except lb_ready=1.
- Enqueue: on lb_valid & lb_ready at a rising edge. lb_ready = (count != DEPTH), computed from the registered count. No enqueue while full, even if a dequeue occurs in the same cycle. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, go to REQ. Head entry is eligible the cycle after its enqueue, so earliest mem_req is at t+1.
  - REQ: mem_req=1, mem_addr={head.address[XLEN-1:2],2'b00}, held stable until mem_ack. On mem_ack, extend the data, latch the result, pop the head, and go to WB. A mem_ack in the first REQ cycle is legal.
  - WB: cdb_valid=1 with latched value/tag/NPC/inst, held stable until cdb_grant. On grant, go to REQ if FIFO non-empty, else IDLE.
  - DRAIN: mem_req=0. Wait for mem_ack of the aborted request, discard its data, then go to IDLE.
- Extension uses byte offset o=address[1:0]:
  - 000 LB: sign-extend byte o
  - 100 LBU: zero-extend byte o
  - 001 LH: sign-extend halfword address[1]
  - 101 LHU: zero-extend halfword address[1]
  - 010 LW: full word
  - any other funct3: value=XLEN'hdeadbeef
- Misaligned halfword/word accesses are not trapped; address bit 0 (and bit 1 for LW) is ignored.
- squash (synchronous, highest priority after reset):
  - FIFO emptied; no enqueue that cycle.
  - cdb_valid deasserts next cycle.
  - In REQ without mem_ack this cycle: go to DRAIN.
  - In REQ with mem_ack this cycle: data discarded, go to IDLE.
  - Otherwise: go to IDLE.
  - lb_ready=1 the cycle after.
- squash while in DRAIN: remain in DRAIN.
- Only one memory request is outstanding at any time. Loads complete on the CDB in FIFO order.

Optional Feature:
- LB_EARLY_WB_EN defined:
  - In a REQ cycle with mem_ack and no squash, cdb_valid/cdb_value/tag/NPC/inst are driven combinationally from mem_rdata and the head entry.
  - If cdb_grant is also asserted that cycle, skip WB and go straight to REQ/IDLE; otherwise latch and enter WB as normal.
  - Load-to-CDB latency is 1 cycle shorter.
- LB_EARLY_WB_EN undefined: cdb_valid is purely registered and is first asserted the cycle after mem_ack.

Test Plan:
- Reset, then lb_valid with address=0x1002, funct3=000, tag=3; mem_ack next cycle with rdata=0x80FF0000 -> mem_addr=0x1000; cdb_value=0xFFFFFFFF, cdb_rob_tag=3, cdb_valid held until cdb_grant.
- LHU at 0x2002, rdata=0x8001_1234 -> cdb_value=0x00008001; LH at 0x2000 with same rdata -> 0x00001234; LW -> 0x80011234.
- Enqueue 4 loads (tags 1-4) with mem_ack withheld -> lb_ready=0 after the 4th; a 5th lb_valid is ignored. Release acks with grants -> CDB tags in order 1,2,3,4; lb_ready returns to 1 after the first pop.
- squash while in REQ with 2 entries queued, mem_ack 3 cycles later with rdata=0x12345678 -> no cdb_valid, no new mem_req until the ack arrives; FSM ends in IDLE; a new load enqueued afterwards completes normally.
- cdb_grant held low for 5 cycles in WB -> cdb_value and cdb_rob_tag stable for all 5 cycles; no new mem_req during WB.
- With LB_EARLY_WB_EN: mem_ack and cdb_grant in the same cycle -> cdb_valid=1 in that cycle, and the next queued load's mem_req is asserted on the following cycle.
